// File: rtl/xmit_frame_formatter_pkg.sv
// xmit_fmt_pkg: shared states, sizes and control-block packing for xmit_frame_formatter
package xmit_fmt_pkg;
    localparam int MAX_LEN_D = 512;
    localparam int MIN_LEN_D = 64;
    localparam int CTRL_W    = 24;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_PRIME, R_SEND, R_GAP} r_state_e;
    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [CTRL_W/2-1:0] len);
        return {len, len};
    endfunction
endpackage

// File: rtl/xmit_frame_formatter_if.sv
// xmit_frame_formatter_if: fabric byte input and xmitTop-facing burst output
interface xmit_frame_formatter_if;
    import xmit_fmt_pkg::*;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_eof;
    logic              in_hi_priority;
    logic              in_ready;
    logic [7:0]        f_data_in;
    logic              f_rec_data_valid;
    logic              f_rec_frame_valid;
    logic [CTRL_W-1:0] f_ctrl_in;
    logic              f_hi_priority;
    modport master (
        output in_data, in_valid, in_sof, in_eof, in_hi_priority,
        input  in_ready, f_data_in, f_rec_data_valid, f_rec_frame_valid, f_ctrl_in, f_hi_priority
    );
    modport slave (
        input  in_data, in_valid, in_sof, in_eof, in_hi_priority,
        output in_ready, f_data_in, f_rec_data_valid, f_rec_frame_valid, f_ctrl_in, f_hi_priority
    );
endinterface

// File: rtl/xmit_frame_formatter_bank_ram.sv
// xmit_fmt_bank_ram: two-bank byte RAM, bank select is the address MSB, 1-cycle read
module xmit_fmt_bank_ram
    import xmit_fmt_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_D,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW:0] waddr,
    input  logic [7:0]  wdata,
    input  logic [AW:0] raddr,
    output logic [7:0]  rdata
);
    logic [7:0] mem [2*MAX_LEN];
    // write port and registered read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/xmit_frame_formatter.sv
// xmit_frame_formatter: store-and-forward ping-pong frame buffer ahead of xmitTop; FMT_STATS_EN adds frame/runt/drop counters
module xmit_frame_formatter
    import xmit_fmt_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_D,
    parameter int MIN_LEN = MIN_LEN_D,
    parameter int LEN_W   = 12,
    parameter int IFG     = 1
) (
    input logic clk_sys,
    input logic reset_n,
    xmit_frame_formatter_if.slave bus
`ifdef FMT_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_runts,
    output logic [15:0] stat_drops
`endif
);
    localparam int AW = $clog2(MAX_LEN);
    w_state_e w_state, w_next;
    r_state_e r_state, r_next;
    logic                  wbank, rbank, wprio, wprio_n, rdy_en, acc, we, commit, free, send, first;
    logic [LEN_W-1:0]      wcount, wcount_n, wlen, rcount, rcount_n;
    logic [1:0]            full, prio_r;
    logic [1:0][LEN_W-1:0] len_r;
    logic [7:0]            gcnt, gcnt_n, rdata;
    logic [AW:0]           waddr, raddr;

    xmit_fmt_bank_ram #(.MAX_LEN(MAX_LEN)) u_ram (
        .clk(clk_sys), .we(we), .waddr(waddr), .wdata(bus.in_data), .raddr(raddr), .rdata(rdata)
    );

    assign bus.in_ready = rdy_en && !full[wbank];
    assign acc  = bus.in_valid && bus.in_ready;
    assign wlen = wcount + LEN_W'(1);

    // write side: SOF restarts at address 0, EOF commits legal lengths, overlong frames are drained
    always_comb begin
        w_next   = w_state;
        wcount_n = wcount;
        wprio_n  = wprio;
        we       = 1'b0;
        commit   = 1'b0;
        waddr    = {wbank, wcount[AW-1:0]};
        if (acc) begin
            case (w_state)
                W_IDLE, W_FILL: begin
                    if (bus.in_sof) begin
                        we       = 1'b1;
                        waddr    = {wbank, {AW{1'b0}}};
                        wcount_n = LEN_W'(1);
                        wprio_n  = bus.in_hi_priority;
                        w_next   = bus.in_eof ? W_IDLE : W_FILL;
                    end else if (w_state == W_FILL) begin
                        we       = 1'b1;
                        wcount_n = wlen;
                        if (bus.in_eof) begin
                            commit = wlen >= LEN_W'(MIN_LEN);
                            w_next = W_IDLE;
                        end else if (wlen == LEN_W'(MAX_LEN)) begin
                            w_next = W_DROP;
                        end
                    end
                end
                default: w_next = bus.in_eof ? W_IDLE : W_DROP;
            endcase
        end
    end

    // write state, fill counter and write bank pointer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            wcount  <= '0;
            wprio   <= 1'b0;
            wbank   <= 1'b0;
            rdy_en  <= 1'b0;
        end else begin
            w_state <= w_next;
            wcount  <= wcount_n;
            wprio   <= wprio_n;
            rdy_en  <= 1'b1;
            if (commit) wbank <= ~wbank;
        end
    end

    // per-bank full flags with length and priority; a commit overrides a free of the same bank
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            full   <= '0;
            len_r  <= '0;
            prio_r <= '0;
        end else begin
            if (free) full[rbank] <= 1'b0;
            if (commit) begin
                full[wbank]   <= 1'b1;
                len_r[wbank]  <= wlen;
                prio_r[wbank] <= wprio;
            end
        end
    end

    // read side: prime address 0, stream len bytes back to back, then hold the inter-frame gap
    always_comb begin
        r_next   = r_state;
        rcount_n = rcount;
        gcnt_n   = gcnt;
        free     = 1'b0;
        raddr    = {rbank, rcount[AW-1:0] + AW'(1)};
        case (r_state)
            R_IDLE: r_next = full[rbank] ? R_PRIME : R_IDLE;
            R_PRIME: begin
                raddr    = {rbank, {AW{1'b0}}};
                rcount_n = '0;
                r_next   = R_SEND;
            end
            R_SEND: begin
                if (rcount == len_r[rbank] - LEN_W'(1)) begin
                    free   = 1'b1;
                    gcnt_n = '0;
                    r_next = (IFG == 0) ? R_IDLE : R_GAP;
                end else begin
                    rcount_n = rcount + LEN_W'(1);
                end
            end
            default: begin
                gcnt_n = gcnt + 8'd1;
                r_next = (gcnt == 8'(IFG - 1)) ? R_IDLE : R_GAP;
            end
        endcase
    end

    // read state, byte counter, gap counter and read bank pointer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            rcount  <= '0;
            gcnt    <= '0;
            rbank   <= 1'b0;
        end else begin
            r_state <= r_next;
            rcount  <= rcount_n;
            gcnt    <= gcnt_n;
            if (free) rbank <= ~rbank;
        end
    end

    assign send                  = r_state == R_SEND;
    assign first                 = send && rcount == '0;
    assign bus.f_data_in         = send ? rdata : 8'd0;
    assign bus.f_rec_data_valid  = send;
    assign bus.f_rec_frame_valid = first;
    assign bus.f_ctrl_in         = first ? pack_ctrl((CTRL_W/2)'(len_r[rbank])) : '0;
    assign bus.f_hi_priority     = send && prio_r[rbank];

`ifdef FMT_STATS_EN
    logic ev_runt, ev_drop;
    assign ev_runt = acc && (bus.in_sof ? (bus.in_eof || w_state == W_FILL)
                                        : (w_state == W_FILL && bus.in_eof && !commit));
    assign ev_drop = acc && !bus.in_sof &&
                     (w_state == W_IDLE || (w_state == W_FILL && !bus.in_eof && wlen == LEN_W'(MAX_LEN)));
    // saturating event counters
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stat_frames <= '0;
            stat_runts  <= '0;
            stat_drops  <= '0;
        end else begin
            stat_frames <= stat_frames + 16'(commit && ~&stat_frames);
            stat_runts  <= stat_runts + 16'(ev_runt && ~&stat_runts);
            stat_drops  <= stat_drops + 16'(ev_drop && ~&stat_drops);
        end
    end
`endif
endmodule

// File: tb/tb_xmit_frame_formatter.sv
// tb_xmit_frame_formatter: randomized frame traffic against a frame-level scoreboard
module tb_xmit_frame_formatter;
    import xmit_fmt_pkg::*;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b1;
    xmit_frame_formatter_if bus();
`ifdef FMT_STATS_EN
    logic [15:0] stat_frames, stat_runts, stat_drops;
`endif
    xmit_frame_formatter dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus)
`ifdef FMT_STATS_EN
        , .stat_frames(stat_frames), .stat_runts(stat_runts), .stat_drops(stat_drops)
`endif
    );
    always #5 clk_sys = ~clk_sys;

    int total = 0, bad = 0, cyc = 0, eof_cyc = 0, first_cyc = 0, nframes = 0, nbytes = 0, n_good = 0;
    int cur_len = 0, idx = 0;
    bit in_frame = 0, prev_valid = 0, saw_nr = 0, cur_prio = 0;
    int exp_len[$];
    bit exp_prio[$];
    logic [7:0] exp_bytes[$];

    always @(posedge clk_sys) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void flag(string name, int act, int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // monitor: pop expected frames and bytes whenever the DUT presents output
    always @(negedge clk_sys) begin
        logic [11:0] l;
        if (reset_n) begin
            if (bus.in_ready === 1'b0) saw_nr = 1;
            if (bus.f_rec_data_valid) begin
                nbytes++;
                if (bus.f_rec_frame_valid) begin
                    if (in_frame) flag("frame_cut_short", idx, cur_len);
                    chk("gap_before_frame", 32'(prev_valid), 0);
                    if (exp_len.size() == 0) flag("unexpected_frame", 1, 0);
                    else begin
                        cur_len  = exp_len.pop_front();
                        cur_prio = exp_prio.pop_front();
                        l        = cur_len[11:0];
                        chk("ctrl", 32'(bus.f_ctrl_in), {8'd0, l, l});
                        in_frame  = 1;
                        idx       = 0;
                        first_cyc = cyc;
                        nframes++;
                    end
                end else chk("ctrl_idle", 32'(bus.f_ctrl_in), 0);
                if (!in_frame || exp_bytes.size() == 0) flag("extra_byte", nbytes, 0);
                else begin
                    chk("byte", 32'(bus.f_data_in), 32'(exp_bytes.pop_front()));
                    chk("prio", 32'(bus.f_hi_priority), 32'(cur_prio));
                    idx++;
                    if (idx == cur_len) in_frame = 0;
                end
            end else begin
                if (in_frame) flag("bubble", idx, cur_len);
                chk("idle_outputs", {bus.f_rec_frame_valid, bus.f_hi_priority, bus.f_ctrl_in}, 0);
            end
            prev_valid = bus.f_rec_data_valid;
        end else begin
            in_frame   = 0;
            prev_valid = 0;
        end
    end

    task automatic beat(input logic [7:0] d, input bit s, input bit e, input bit p);
        int w = 0;
        bus.in_data = d;
        bus.in_sof = s;
        bus.in_eof = e;
        bus.in_hi_priority = p;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && w < 20000) begin
            @(posedge clk_sys);
            #1;
            w++;
        end
        if (w >= 20000) begin
            $display("FAIL ready_timeout: got in_ready=%b after %0d cycles expected 1", bus.in_ready, w);
            $fatal(1, "in_ready stuck low");
        end
        if (e) eof_cyc = cyc;
        @(posedge clk_sys);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // model: a frame emerges iff it ends with EOF and MIN_LEN <= len <= MAX_LEN
    task automatic send_frame(input int len, input bit prio, input bit eof_en, input bit inc, input int gap_pct);
        logic [7:0] q[$];
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = inc ? 8'(i) : 8'($urandom);
            q.push_back(d);
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(posedge clk_sys);
                #1;
            end
            beat(d, i == 0, eof_en && i == len - 1, i == 0 ? prio : 1'($urandom));
        end
        if (eof_en && len >= MIN_LEN_D && len <= MAX_LEN_D) begin
            exp_len.push_back(len);
            exp_prio.push_back(prio);
            foreach (q[k]) exp_bytes.push_back(q[k]);
            n_good++;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_len.size() != 0 || in_frame) && w < 30000) begin
            @(negedge clk_sys);
            #1;
            w++;
        end
        @(negedge clk_sys);
        #1;
        chk("drain_frames_left", 32'(exp_len.size()), 0);
        chk("drain_in_frame", 32'(in_frame), 0);
    endtask

    initial begin
        int w, k, nb0;
        bit last_abandon;
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_sof = 0;
        bus.in_eof = 0;
        bus.in_hi_priority = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_ctrl", 32'(bus.f_ctrl_in), 0);
        chk("rst_flags", {bus.f_rec_data_valid, bus.f_rec_frame_valid, bus.f_hi_priority, bus.f_data_in}, 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        #1 chk("ready_before_edge", 32'(bus.in_ready), 0);
        @(posedge clk_sys);
        #1 chk("ready_after_rst", 32'(bus.in_ready), 1);

        send_frame(64, 0, 1, 1, 0);
        drain();
        chk("t1_latency", 32'(first_cyc - eof_cyc), 3);
        chk("t1_frames", 32'(nframes), 1);

        send_frame(512, 1, 1, 0, 0);
        send_frame(64, 0, 1, 0, 0);
        drain();
        chk("t2_frames", 32'(nframes), 3);

        saw_nr = 0;
        repeat (3) send_frame(512, 1'($urandom), 1, 0, 0);
        drain();
        chk("t3_ready_dropped", 32'(saw_nr), 1);
        chk("t3_frames", 32'(nframes), 6);

        send_frame(40, 0, 1, 0, 0);
        send_frame(600, 1, 1, 0, 0);
        send_frame(64, 1, 1, 0, 0);
        drain();
        chk("t4_frames", 32'(nframes), 7);
`ifdef FMT_STATS_EN
        chk("stat_frames", 32'(stat_frames), 32'(n_good));
        chk("stat_runts", 32'(stat_runts), 1);
        chk("stat_drops", 32'(stat_drops), 1);
`endif

        send_frame(30, 0, 0, 0, 0);
        send_frame(100, 1, 1, 0, 0);
        drain();
        chk("t5_frames", 32'(nframes), 8);

        last_abandon = 0;
        repeat (30) begin
            k = int'($urandom_range(9));
            if (last_abandon && k >= 9) k = 0;
            if (k <= 5) send_frame(int'($urandom_range(64, 512)), 1'($urandom), 1, 0, $urandom_range(1) ? 20 : 0);
            else if (k == 6) send_frame(int'($urandom_range(1, 63)), 1'($urandom), 1, 0, 0);
            else if (k == 7) send_frame(int'($urandom_range(513, 700)), 1'($urandom), 1, 0, 0);
            else if (k == 8) send_frame(int'($urandom_range(1, 200)), 1'($urandom), 0, 0, 0);
            else beat(8'($urandom), 0, 1'($urandom), 1'($urandom));
            last_abandon = (k == 8);
            repeat ($urandom_range(3)) begin
                @(posedge clk_sys);
                #1;
            end
        end
        drain();

        send_frame(512, 1, 1, 0, 0);
        w = 0;
        while (!(in_frame && idx == 200) && w < 5000) begin
            @(negedge clk_sys);
            #1;
            w++;
        end
        chk("rst_reach_byte200", 32'(idx), 200);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {bus.f_rec_data_valid, bus.f_rec_frame_valid, bus.f_hi_priority}, 0);
        chk("async_rst_data", 32'(bus.f_data_in), 0);
        chk("async_rst_ready", 32'(bus.in_ready), 0);
        exp_len.delete();
        exp_prio.delete();
        exp_bytes.delete();
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        nb0 = nbytes;
        repeat (40) @(negedge clk_sys);
        #1 chk("no_residual_bytes", 32'(nbytes - nb0), 0);
        send_frame(64, 0, 1, 1, 0);
        drain();
        chk("post_rst_frames", 32'(nbytes - nb0), 64);
`ifdef FMT_STATS_EN
        chk("post_rst_stat_frames", 32'(stat_frames), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
